// File: rtl/cam_capture_fifo_pkg.sv
// Shared types and default sizing for the camera capture path and the
// data-path mux that consumes its cam_data bus.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } cam_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int CAM_DEPTH   = 16;
    localparam int CAM_LEN_W   = 11;

endpackage

// File: rtl/cam_capture_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; a pop on a full FIFO frees the slot for a
// same-cycle push, while a pop on an empty FIFO is ignored.
module sync_fifo
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cam_capture_fifo.sv
// DVP camera capture: synchronises PCLK/VSYNC/HREF/D into clk, frames the
// stream by VSYNC/HREF and buffers active-line bytes for the pico read path.
module cam_capture_fifo
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH,
    parameter int LEN_W = CAM_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_d,
    input  logic             rd_req,
    output logic [7:0]       cam_data,
    output logic             data_valid,
    output logic             frame_start,
    output logic             line_end,
    output logic [LEN_W-1:0] line_len,
    output logic             overflow
);

    // Index SYNC_STAGES-1 is the synced level, index SYNC_STAGES its previous value.
    logic [SYNC_STAGES:0] pclk_sh;
    logic [SYNC_STAGES:0] vs_sh;
    logic [SYNC_STAGES:0] href_sh;
    logic [7:0]           d_sh [SYNC_STAGES];

    logic pclk_rise, vs_fall, vs_rise, href_fall, href_level;
    cam_state_t state, next_state;
    logic frame_start_d, line_end_d, byte_strobe;
    logic [LEN_W-1:0] line_cnt;
    logic fifo_full, fifo_empty;

    assign pclk_rise  =  pclk_sh[SYNC_STAGES-1] & ~pclk_sh[SYNC_STAGES];
    assign vs_fall    = ~vs_sh[SYNC_STAGES-1]   &  vs_sh[SYNC_STAGES];
    assign vs_rise    =  vs_sh[SYNC_STAGES-1]   & ~vs_sh[SYNC_STAGES];
    assign href_fall  = ~href_sh[SYNC_STAGES-1] &  href_sh[SYNC_STAGES];
    assign href_level =  href_sh[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sh <= '0;
            vs_sh   <= '0;
            href_sh <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) d_sh[i] <= '0;
        end else begin
            pclk_sh <= {pclk_sh[SYNC_STAGES-1:0], cam_pclk};
            vs_sh   <= {vs_sh[SYNC_STAGES-1:0], cam_vsync};
            href_sh <= {href_sh[SYNC_STAGES-1:0], cam_href};
            d_sh[0] <= cam_d;
            for (int i = 1; i < SYNC_STAGES; i++) d_sh[i] <= d_sh[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:       next_state = WAIT_FRAME;
                WAIT_FRAME: if (vs_fall) next_state = CAPTURE;
                CAPTURE:    if (vs_rise) next_state = WAIT_FRAME;
                default:    next_state = IDLE;
            endcase
        end
    end

    // Dropping enable suppresses every event, so an aborted line never reports.
    always_comb begin
        frame_start_d = enable && (state == WAIT_FRAME) && vs_fall;
        line_end_d    = enable && (state == CAPTURE) && href_fall;
        byte_strobe   = enable && (state == CAPTURE) && pclk_rise && href_level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            line_len    <= '0;
            line_cnt    <= '0;
            overflow    <= 1'b0;
        end else begin
            frame_start <= frame_start_d;
            line_end    <= line_end_d;
            if (frame_start_d) begin
                line_cnt <= '0;
            end else if (line_end_d) begin
                line_len <= line_cnt;
                line_cnt <= '0;
            end else if (byte_strobe && (line_cnt != '1)) begin
                line_cnt <= line_cnt + LEN_W'(1);
            end
            if (!enable)
                overflow <= 1'b0;
            else if (byte_strobe && fifo_full && !(rd_req && !fifo_empty))
                overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (byte_strobe),
        .push_data (d_sh[SYNC_STAGES-1]),
        .pop       (rd_req),
        .head      (cam_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_valid = ~fifo_empty;

endmodule

// File: tb/tb_cam_capture_fifo.sv
// Directed bench for cam_capture_fifo: drives a DVP camera at pclk = clk/4
// and compares outputs against hand-computed expectations.
module tb_cam_capture_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cam_pclk;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_d;
    logic        rd_req;
    logic [7:0]  cam_data;
    logic        data_valid;
    logic        frame_start;
    logic        line_end;
    logic [10:0] line_len;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;
    int fs_count    = 0;
    int le_count    = 0;
    logic [10:0] last_len = '0;

    cam_capture_fifo #(.DEPTH(16), .LEN_W(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cam_pclk    (cam_pclk),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_d       (cam_d),
        .rd_req      (rd_req),
        .cam_data    (cam_data),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .line_end    (line_end),
        .line_len    (line_len),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Each cycle a pulse is high counts once, so a stretched pulse shows up as extra counts.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_start) fs_count = fs_count + 1;
            if (line_end) begin
                le_count = le_count + 1;
                last_len = line_len;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One camera byte: PCLK low for 2 clk, high for 2 clk, data held throughout.
    task automatic applyStimulus(input logic [7:0] b);
        cam_d    = b;
        cam_pclk = 1'b0;
        ticks(2);
        cam_pclk = 1'b1;
        ticks(2);
    endtask

    task automatic sendLine(input logic [7:0] first, input int n);
        logic [7:0] b;
        cam_href = 1'b1;
        b = first;
        for (int i = 0; i < n; i++) begin
            applyStimulus(b);
            b = b + 8'd1;
        end
        ticks(2);
        cam_href = 1'b0;
        ticks(6);
    endtask

    task automatic drainExpect(input string tag, input logic [7:0] first, input int n);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            checkOutput(tag, {23'd0, data_valid, cam_data}, {23'd0, 1'b1, b});
            rd_req = 1'b1;
            ticks(1);
            b = b + 8'd1;
        end
        rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0;
        cam_href = 1'b0; cam_d = 8'h00; rd_req = 1'b0;
        ticks(3);
        checkOutput("rst_cam_data",    cam_data,    0);
        checkOutput("rst_data_valid",  data_valid,  0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_line_end",    line_end,    0);
        checkOutput("rst_line_len",    line_len,    0);
        checkOutput("rst_overflow",    overflow,    0);
        rst = 1'b0;

        // Gating: bytes before the first VSYNC fall and bytes with HREF low are dropped.
        enable = 1'b1; cam_vsync = 1'b1;
        ticks(4);
        sendLine(8'hAA, 1);
        checkOutput("pre_vsync_nopush", data_valid, 0);
        cam_vsync = 1'b0;
        ticks(4);
        checkOutput("frame_start_once", fs_count, 1);
        applyStimulus(8'h55);
        ticks(4);
        checkOutput("href_low_nopush", data_valid, 0);

        // Basic capture of 8 bytes, then drained at 1 byte/cycle.
        sendLine(8'h10, 8);
        checkOutput("basic_line_end", le_count, 1);
        checkOutput("basic_line_len", last_len, 8);
        drainExpect("basic_drain", 8'h10, 8);
        checkOutput("basic_empty_valid", data_valid, 0);
        checkOutput("basic_empty_data",  cam_data,   0);

        // Popping an empty FIFO changes nothing.
        rd_req = 1'b1;
        ticks(2);
        rd_req = 1'b0;
        checkOutput("empty_pop_data",  cam_data,   0);
        checkOutput("empty_pop_valid", data_valid, 0);
        checkOutput("empty_pop_ovf",   overflow,   0);

        // Overflow: 20 bytes into 16 slots with no reads.
        sendLine(8'h20, 20);
        checkOutput("ovf_valid",    data_valid, 1);
        checkOutput("ovf_head",     cam_data,   8'h20);
        checkOutput("ovf_flag",     overflow,   1);
        checkOutput("ovf_line_len", last_len,   20);
        ticks(10);
        checkOutput("ovf_sticky",   overflow,   1);
        enable = 1'b0;
        ticks(2);
        checkOutput("ovf_cleared",   overflow,   0);
        checkOutput("ovf_retained",  data_valid, 1);
        enable = 1'b1;
        cam_vsync = 1'b1;
        ticks(4);
        cam_vsync = 1'b0;
        ticks(4);
        checkOutput("frame_start_second", fs_count, 2);

        // Full boundary: the push edge of byte 0x40 coincides with a pop.
        cam_href = 1'b1;
        applyStimulus(8'h40);
        rd_req = 1'b1;
        ticks(1);
        rd_req = 1'b0;
        ticks(2);
        cam_href = 1'b0;
        ticks(6);
        checkOutput("full_no_ovf",   overflow, 0);
        checkOutput("full_line_len", last_len, 1);
        drainExpect("full_drain", 8'h21, 15);
        drainExpect("full_tail",  8'h40, 1);
        checkOutput("full_then_empty", data_valid, 0);

        // Abort mid-line: 3 bytes, then enable low while HREF is still high.
        cam_href = 1'b1;
        applyStimulus(8'h50);
        applyStimulus(8'h51);
        applyStimulus(8'h52);
        ticks(2);
        enable = 1'b0;
        ticks(1);
        applyStimulus(8'h99);
        ticks(2);
        cam_href = 1'b0;
        ticks(6);
        checkOutput("abort_no_line_end", le_count, 3);
        drainExpect("abort_drain", 8'h50, 3);
        checkOutput("abort_empty", data_valid, 0);
        enable = 1'b1;
        ticks(2);
        sendLine(8'h60, 1);
        checkOutput("reenable_needs_vsync", data_valid, 0);

        // Reset in the middle of a frame with data buffered.
        cam_vsync = 1'b1;
        ticks(4);
        cam_vsync = 1'b0;
        ticks(4);
        checkOutput("frame_start_third", fs_count, 3);
        cam_href = 1'b1;
        applyStimulus(8'h70);
        applyStimulus(8'h71);
        ticks(2);
        checkOutput("pre_rst_valid", data_valid, 1);
        rst = 1'b1;
        ticks(1);
        checkOutput("midrst_valid",    data_valid,  0);
        checkOutput("midrst_data",     cam_data,    0);
        checkOutput("midrst_line_len", line_len,    0);
        checkOutput("midrst_overflow", overflow,    0);
        checkOutput("midrst_fs",       frame_start, 0);
        checkOutput("midrst_le",       line_end,    0);
        rst = 1'b0;
        cam_href = 1'b0;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
